pcileech_ft601_emu: RTL and testbench

//  Synthesizable chip-side model of the FT601 245-synchronous-FIFO bus: the responder to the

---
 rtl/pcileech_ft601_emu_pkg.sv | 72 +++++++
 rtl/pcileech_ft601_emu_fifo.sv | 92 +++++++++
 rtl/pcileech_ft601_emu.sv | 176 +++++++++++++++++
 tb/tb_pcileech_ft601_emu.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_ft601_emu_pkg.sv
// ---------------------------------------------------------------------------
// pcileech_ft601_emu_pkg
//   Shared types and helpers for the FT601 chip-side emulator.
//   - FT601 bus widths (data, byte enables, and the combined write-FIFO word).
//   - Pacer state enum (ACT / GAP) and the per-direction pacer record.
//   - pace_next(): one clock step of a burst/gap pacer.
//   - sat_inc16(): saturating increment for the 16-bit error counters.
// ---------------------------------------------------------------------------
package pcileech_ft601_emu_pkg;

  localparam int FT_DATA_W  = 32;
  localparam int FT_BE_W    = 4;
  localparam int FT_WR_W    = FT_DATA_W + FT_BE_W;
  localparam int PACE_CNT_W = 16;

  typedef enum logic {
    PACE_ACT = 1'b0,
    PACE_GAP = 1'b1
  } pace_state_e;

  // One pacer: the FSM state, transfers seen in the current burst, and the
  // remaining forced-idle cycles while in GAP.
  typedef struct packed {
    pace_state_e             state;
    logic [PACE_CNT_W-1:0]   burst_cnt;
    logic [PACE_CNT_W-1:0]   gap_cnt;
  } pace_t;

  localparam pace_t PACE_RESET = '{state: PACE_ACT, burst_cnt: '0, gap_cnt: '0};

  // Next pacer value given whether a transfer happens on this edge.
  // burst == 0 disables pacing entirely. A burst that completes with gap == 0
  // simply restarts counting instead of entering a zero-length GAP.
  function automatic pace_t pace_next(
    input pace_t                 cur,
    input logic                  xfer,
    input logic [PACE_CNT_W-1:0] burst,
    input logic [PACE_CNT_W-1:0] gap
  );
    pace_t nxt;
    nxt = cur;
    case (cur.state)
      PACE_ACT: begin
        if (xfer && (burst != '0)) begin
          nxt.burst_cnt = cur.burst_cnt + 1'b1;
          if (nxt.burst_cnt == burst) begin
            if (gap == '0) begin
              nxt.burst_cnt = '0;
            end else begin
              nxt.state   = PACE_GAP;
              nxt.gap_cnt = gap;
            end
          end
        end
      end
      PACE_GAP: begin
        nxt.gap_cnt = cur.gap_cnt - 1'b1;
        if (nxt.gap_cnt == '0) begin
          nxt.state     = PACE_ACT;
          nxt.burst_cnt = '0;
        end
      end
      default: nxt = PACE_RESET;
    endcase
    return nxt;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    return (en && (val != 16'hFFFF)) ? val + 16'd1 : val;
  endfunction

endpackage

// File: rtl/pcileech_ft601_emu_fifo.sv
// ---------------------------------------------------------------------------
// pcileech_ft601_emu_fifo
//   Synchronous first-word-fall-through FIFO with a registered head word.
//   The head register always holds the oldest entry (or zero when empty), so
//   consumers see data in the same cycle the count becomes non-zero.
//   A pop and a push on the same edge are both honoured: a full FIFO still
//   accepts a push that coincides with a pop.
//
//   Ports
//     i_clk        clock
//     i_flush      synchronous clear of pointers, count and head
//     i_push       push request; ignored when full unless popping too
//     i_data       word to push
//     i_pop        pop request; ignored when empty
//     o_head       oldest word (zero while empty)
//     o_count      current occupancy
//     o_count_nxt  occupancy after this edge (for look-ahead flags)
// ---------------------------------------------------------------------------
module pcileech_ft601_emu_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [DEPTH_LOG2:0]   o_count_nxt
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic [DEPTH_LOG2-1:0]  r_rd_ptr;
  logic [DEPTH_LOG2:0]    r_count;
  logic [WIDTH-1:0]       r_head;

  logic                   w_pop;
  logic                   w_push;
  logic [DEPTH_LOG2-1:0]  w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]    w_count_after_pop;
  logic [DEPTH_LOG2:0]    w_count_nxt;

  assign w_pop             = i_pop && (r_count != '0);
  assign w_push            = i_push && ((r_count != FULL_CNT) || w_pop);
  assign w_rd_ptr_nxt      = r_rd_ptr + DEPTH_LOG2'(w_pop);
  assign w_count_after_pop = r_count - (DEPTH_LOG2 + 1)'(w_pop);
  assign w_count_nxt       = w_count_after_pop + (DEPTH_LOG2 + 1)'(w_push);

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count alone, which keeps the array mappable to RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      // Head selection: empty -> zero; the only surviving word is the one
      // arriving now -> bypass it; otherwise read the next stored entry.
      if (w_count_nxt == '0) begin
        r_head <= '0;
      end else if (w_count_after_pop == '0) begin
        r_head <= i_data;
      end else begin
        r_head <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign o_head      = r_head;
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;

endmodule

// File: rtl/pcileech_ft601_emu.sv
// ---------------------------------------------------------------------------
// pcileech_ft601_emu
//   Chip-side model of the FT601 245-synchronous FIFO bus. It answers the
//   FPGA master's pins so the FT601 path can run board-less (loopback or
//   simulation). Host stream ports stand in for the USB host:
//     host_tx_* -> RD FIFO -> ft601_data_o  (FPGA reads)
//     ft601_data_i/be -> WR FIFO -> host_rx_*  (FPGA writes)
//   Burst/gap pacers per direction force rxf_n/txe_n high periodically to
//   exercise the master's back-pressure handling.
//
//   Ports
//     clk, rst               bus clock; synchronous active-high reset
//     ft601_rst_n            chip reset from FPGA, low flushes like rst
//     ft601_data_i/o/oe      bus data in, data out, chip-drives-bus enable
//     ft601_be               byte enables captured with each write
//     ft601_rxf_n/txe_n      chip status flags (low = word ready / space)
//     ft601_wr_n/rd_n/oe_n   FPGA strobes
//     ft601_siwu_n           unused tie-off
//     host_tx_*              host push stream toward the FPGA
//     host_rx_*              host pop stream of FPGA-written words
//     err_ovr_cnt            writes attempted while txe_n=1 (saturating)
//     err_udr_cnt            reads attempted while rxf_n=1 (saturating)
// ---------------------------------------------------------------------------
module pcileech_ft601_emu
  import pcileech_ft601_emu_pkg::*;
#(
  parameter int PARAM_DEPTH_LOG2 = 4,
  parameter int PARAM_TXE_BURST  = 0,
  parameter int PARAM_TXE_GAP    = 2,
  parameter int PARAM_RXF_BURST  = 0,
  parameter int PARAM_RXF_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ft601_rst_n,
  input  logic [FT_DATA_W-1:0] ft601_data_i,
  output logic [FT_DATA_W-1:0] ft601_data_o,
  output logic                 ft601_data_oe,
  input  logic [FT_BE_W-1:0]   ft601_be,
  output logic                 ft601_rxf_n,
  output logic                 ft601_txe_n,
  input  logic                 ft601_wr_n,
  input  logic                 ft601_rd_n,
  input  logic                 ft601_oe_n,
  input  logic                 ft601_siwu_n,
  input  logic [FT_DATA_W-1:0] host_tx_data,
  input  logic                 host_tx_valid,
  output logic                 host_tx_ready,
  output logic [FT_DATA_W-1:0] host_rx_data,
  output logic [FT_BE_W-1:0]   host_rx_be,
  output logic                 host_rx_valid,
  input  logic                 host_rx_ready,
  output logic [15:0]          err_ovr_cnt,
  output logic [15:0]          err_udr_cnt
);

  localparam logic [PARAM_DEPTH_LOG2:0] FULL_CNT =
    (PARAM_DEPTH_LOG2 + 1)'(1 << PARAM_DEPTH_LOG2);
  localparam logic [PACE_CNT_W-1:0] TXE_BURST = PACE_CNT_W'(PARAM_TXE_BURST);
  localparam logic [PACE_CNT_W-1:0] TXE_GAP   = PACE_CNT_W'(PARAM_TXE_GAP);
  localparam logic [PACE_CNT_W-1:0] RXF_BURST = PACE_CNT_W'(PARAM_RXF_BURST);
  localparam logic [PACE_CNT_W-1:0] RXF_GAP   = PACE_CNT_W'(PARAM_RXF_GAP);

  // Registered outputs and pacer state.
  logic        r_data_oe;
  logic        r_rxf_n;
  logic        r_txe_n;
  logic        r_host_tx_ready;
  logic        r_host_rx_valid;
  logic [15:0] r_err_ovr;
  logic [15:0] r_err_udr;
  pace_t       r_rxf_pace;
  pace_t       r_txe_pace;

  logic                      w_flush;
  logic                      w_rd_pop;
  logic                      w_wr_push;
  logic                      w_rd_udr;
  logic                      w_wr_ovr;
  logic [FT_DATA_W-1:0]      w_rd_head;
  logic [FT_WR_W-1:0]        w_wr_head;
  logic [PARAM_DEPTH_LOG2:0] w_rd_cnt;
  logic [PARAM_DEPTH_LOG2:0] w_rd_cnt_nxt;
  logic [PARAM_DEPTH_LOG2:0] w_wr_cnt;
  logic [PARAM_DEPTH_LOG2:0] w_wr_cnt_nxt;
  pace_t                     w_rxf_pace_nxt;
  pace_t                     w_txe_pace_nxt;
  logic                      w_unused;

  assign w_flush = rst || !ft601_rst_n;

  // Transfers are qualified by the registered flags the FPGA actually saw;
  // strobes against a raised flag are dropped and only counted as errors.
  assign w_rd_pop  = !ft601_oe_n && !ft601_rd_n && !r_rxf_n;
  assign w_wr_push = !ft601_wr_n && !r_txe_n;
  assign w_rd_udr  = !ft601_rd_n && r_rxf_n;
  assign w_wr_ovr  = !ft601_wr_n && r_txe_n;

  // RD FIFO: host -> FPGA.
  pcileech_ft601_emu_fifo #(
    .WIDTH      (FT_DATA_W),
    .DEPTH_LOG2 (PARAM_DEPTH_LOG2)
  ) u_rd_fifo (
    .i_clk       (clk),
    .i_flush     (w_flush),
    .i_push      (host_tx_valid),
    .i_data      (host_tx_data),
    .i_pop       (w_rd_pop),
    .o_head      (w_rd_head),
    .o_count     (w_rd_cnt),
    .o_count_nxt (w_rd_cnt_nxt)
  );

  // WR FIFO: FPGA -> host, byte enables travel with their word.
  pcileech_ft601_emu_fifo #(
    .WIDTH      (FT_WR_W),
    .DEPTH_LOG2 (PARAM_DEPTH_LOG2)
  ) u_wr_fifo (
    .i_clk       (clk),
    .i_flush     (w_flush),
    .i_push      (w_wr_push),
    .i_data      ({ft601_be, ft601_data_i}),
    .i_pop       (host_rx_ready),
    .o_head      (w_wr_head),
    .o_count     (w_wr_cnt),
    .o_count_nxt (w_wr_cnt_nxt)
  );

  // NOTE: always_comb writes every output on every pass, so no latch can be
  // inferred for the pacer look-ahead values.
  always_comb begin
    w_rxf_pace_nxt = pace_next(r_rxf_pace, w_rd_pop,  RXF_BURST, RXF_GAP);
    w_txe_pace_nxt = pace_next(r_txe_pace, w_wr_push, TXE_BURST, TXE_GAP);
  end

  // Flags are derived from post-edge occupancy and pacer state, so they are
  // already correct on the edge that performs the last permitted transfer.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_data_oe       <= 1'b0;
      r_rxf_n         <= 1'b1;
      r_txe_n         <= 1'b1;
      r_host_tx_ready <= 1'b1;
      r_host_rx_valid <= 1'b0;
      r_err_ovr       <= '0;
      r_err_udr       <= '0;
      r_rxf_pace      <= PACE_RESET;
      r_txe_pace      <= PACE_RESET;
    end else begin
      r_data_oe       <= !ft601_oe_n;
      r_rxf_pace      <= w_rxf_pace_nxt;
      r_txe_pace      <= w_txe_pace_nxt;
      r_rxf_n         <= (w_rd_cnt_nxt == '0) || (w_rxf_pace_nxt.state == PACE_GAP);
      r_txe_n         <= (w_wr_cnt_nxt == FULL_CNT) || (w_txe_pace_nxt.state == PACE_GAP);
      r_host_tx_ready <= (w_rd_cnt_nxt != FULL_CNT);
      r_host_rx_valid <= (w_wr_cnt_nxt != '0);
      r_err_ovr       <= sat_inc16(r_err_ovr, w_wr_ovr);
      r_err_udr       <= sat_inc16(r_err_udr, w_rd_udr);
    end
  end

  assign ft601_data_o  = w_rd_head;
  assign ft601_data_oe = r_data_oe;
  assign ft601_rxf_n   = r_rxf_n;
  assign ft601_txe_n   = r_txe_n;
  assign host_tx_ready = r_host_tx_ready;
  assign host_rx_data  = w_wr_head[FT_DATA_W-1:0];
  assign host_rx_be    = w_wr_head[FT_WR_W-1:FT_DATA_W];
  assign host_rx_valid = r_host_rx_valid;
  assign err_ovr_cnt   = r_err_ovr;
  assign err_udr_cnt   = r_err_udr;

  // Wake-up pin and current occupancies are not needed by this model.
  assign w_unused = ^{ft601_siwu_n, w_rd_cnt, w_wr_cnt};

endmodule

// File: tb/tb_pcileech_ft601_emu.sv
module tb_pcileech_ft601_emu;

  localparam int TXB   = 4;
  localparam int TXG   = 2;
  localparam int RXB   = 3;
  localparam int RXG   = 1;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ft601_rst_n;
  logic [31:0] ft601_data_i;
  logic [31:0] ft601_data_o;
  logic        ft601_data_oe;
  logic [3:0]  ft601_be;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_wr_n;
  logic        ft601_rd_n;
  logic        ft601_oe_n;
  logic        ft601_siwu_n;
  logic [31:0] host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready;
  logic [31:0] host_rx_data;
  logic [3:0]  host_rx_be;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [15:0] err_ovr_cnt;
  logic [15:0] err_udr_cnt;

  pcileech_ft601_emu #(
    .PARAM_DEPTH_LOG2 (4),
    .PARAM_TXE_BURST  (TXB),
    .PARAM_TXE_GAP    (TXG),
    .PARAM_RXF_BURST  (RXB),
    .PARAM_RXF_GAP    (RXG)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ft601_rst_n   (ft601_rst_n),
    .ft601_data_i  (ft601_data_i),
    .ft601_data_o  (ft601_data_o),
    .ft601_data_oe (ft601_data_oe),
    .ft601_be      (ft601_be),
    .ft601_rxf_n   (ft601_rxf_n),
    .ft601_txe_n   (ft601_txe_n),
    .ft601_wr_n    (ft601_wr_n),
    .ft601_rd_n    (ft601_rd_n),
    .ft601_oe_n    (ft601_oe_n),
    .ft601_siwu_n  (ft601_siwu_n),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_be    (host_rx_be),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .err_ovr_cnt   (err_ovr_cnt),
    .err_udr_cnt   (err_udr_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: two queues plus burst/gap bookkeeping per direction.
  logic [31:0] m_rd[$];
  logic [35:0] m_wr[$];
  int          m_tx_cnt, m_tx_gap, m_rx_cnt, m_rx_gap;
  int          m_ovr, m_udr;
  logic        m_rxf_n, m_txe_n, m_oe;
  logic [35:0] cap_q[$];

  function automatic void pace(inout int cnt, inout int gap_left, input bit xfer,
                               input int burst, input int glen);
    if (gap_left > 0) begin
      gap_left--;
      if (gap_left == 0) cnt = 0;
    end else if (xfer) begin
      cnt++;
      if (burst > 0 && cnt == burst) begin
        if (glen > 0) gap_left = glen;
        else cnt = 0;
      end
    end
  endfunction

  function automatic void model_step();
    bit rd_pop, wr_push, h_pop, h_push;
    if (rst || !ft601_rst_n) begin
      m_rd.delete();
      m_wr.delete();
      m_tx_cnt = 0; m_tx_gap = 0; m_rx_cnt = 0; m_rx_gap = 0;
      m_ovr = 0; m_udr = 0;
      m_rxf_n = 1'b1; m_txe_n = 1'b1; m_oe = 1'b0;
      return;
    end
    rd_pop  = !ft601_oe_n && !ft601_rd_n && !m_rxf_n;
    wr_push = !ft601_wr_n && !m_txe_n;
    if (!ft601_rd_n && m_rxf_n && m_udr < 65535) m_udr++;
    if (!ft601_wr_n && m_txe_n && m_ovr < 65535) m_ovr++;
    h_pop  = host_rx_ready && (m_wr.size() > 0);
    h_push = host_tx_valid && ((m_rd.size() < DEPTH) || rd_pop);
    if (rd_pop)  void'(m_rd.pop_front());
    if (h_push)  m_rd.push_back(host_tx_data);
    if (h_pop)   void'(m_wr.pop_front());
    if (wr_push) m_wr.push_back({ft601_be, ft601_data_i});
    pace(m_tx_cnt, m_tx_gap, wr_push, TXB, TXG);
    pace(m_rx_cnt, m_rx_gap, rd_pop, RXB, RXG);
    m_oe    = !ft601_oe_n;
    m_txe_n = (m_wr.size() == DEPTH) || (m_tx_gap > 0);
    m_rxf_n = (m_rd.size() == 0) || (m_rx_gap > 0);
  endfunction

  task automatic compare_all();
    check("rxf_n",    64'(ft601_rxf_n),   64'(m_rxf_n));
    check("txe_n",    64'(ft601_txe_n),   64'(m_txe_n));
    check("data_oe",  64'(ft601_data_oe), 64'(m_oe));
    check("tx_ready", 64'(host_tx_ready), 64'(m_rd.size() < DEPTH));
    check("rx_valid", 64'(host_rx_valid), 64'(m_wr.size() > 0));
    check("ovr_cnt",  64'(err_ovr_cnt),   64'(m_ovr));
    check("udr_cnt",  64'(err_udr_cnt),   64'(m_udr));
    if (m_rd.size() > 0) check("data_o", 64'(ft601_data_o), 64'(m_rd[0]));
    if (m_wr.size() > 0) check("rx_word", 64'({host_rx_be, host_rx_data}), 64'(m_wr[0]));
  endtask

  // One bus cycle: inputs are already set; model predicts, DUT clocks, compare.
  task automatic tick();
    if (host_rx_valid && host_rx_ready) cap_q.push_back({host_rx_be, host_rx_data});
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst = 1'b0; ft601_rst_n = 1'b1;
    ft601_oe_n = 1'b1; ft601_rd_n = 1'b1; ft601_wr_n = 1'b1;
    ft601_data_i = '0; ft601_be = 4'h0; ft601_siwu_n = 1'b1;
    host_tx_valid = 1'b0; host_tx_data = '0; host_rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rxf_n",    64'(ft601_rxf_n),   64'(1));
    check("rst_txe_n",    64'(ft601_txe_n),   64'(1));
    check("rst_data_oe",  64'(ft601_data_oe), 64'(0));
    check("rst_data_o",   64'(ft601_data_o),  64'(0));
    check("rst_rx_valid", 64'(host_rx_valid), 64'(0));
    check("rst_tx_ready", 64'(host_tx_ready), 64'(1));
    check("rst_err",      64'({err_ovr_cnt, err_udr_cnt}), 64'(0));
    rst = 1'b0;
    tick();
  endtask

  task automatic host_push(input logic [31:0] w);
    host_tx_valid = 1'b1; host_tx_data = w;
    tick();
    host_tx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  txe_pat;
    logic [31:0] rq[$];
    int          acc, n;

    idle();
    @(negedge clk);

    // 1. Reset
    do_reset();

    // 2. Host read burst
    host_push(32'h1111_1111);
    host_push(32'h2222_2222);
    host_push(32'h3333_3333);
    ft601_oe_n = 1'b0;
    tick();
    ft601_rd_n = 1'b0;
    check("rd_rxf_low", 64'(ft601_rxf_n), 64'(0));
    check("rd_word0", 64'(ft601_data_o), 64'h1111_1111); tick();
    check("rd_word1", 64'(ft601_data_o), 64'h2222_2222); tick();
    check("rd_word2", 64'(ft601_data_o), 64'h3333_3333); tick();
    ft601_rd_n = 1'b1;
    check("rd_rxf_after", 64'(ft601_rxf_n), 64'(1));
    check("rd_udr", 64'(err_udr_cnt), 64'(0));

    // 3. Write loopback
    do_reset();
    cap_q.delete();
    host_rx_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 60 && (acc < 5 || cap_q.size() < 5); k++) begin
      if (acc < 5 && !ft601_txe_n) begin
        ft601_wr_n = 1'b0; ft601_be = 4'hF; ft601_data_i = 32'hA0 + 32'(acc);
        acc++;
      end else begin
        ft601_wr_n = 1'b1;
      end
      tick();
    end
    ft601_wr_n = 1'b1;
    check("wl_count", 64'(cap_q.size()), 64'(5));
    for (int i = 0; i < cap_q.size() && i < 5; i++)
      check($sformatf("wl_word%0d", i), 64'(cap_q[i]), 64'({4'hF, 32'hA0 + 32'(i)}));

    // 4. Pacing: FPGA ignores txe_n for 8 back-to-back write cycles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      txe_pat[i] = ft601_txe_n;
      ft601_wr_n = 1'b0; ft601_be = 4'hF; ft601_data_i = 32'hB0 + 32'(i);
      tick();
    end
    ft601_wr_n = 1'b1;
    check("pace_txe_pattern", 64'(txe_pat), 64'h30);
    check("pace_ovr", 64'(err_ovr_cnt), 64'(2));
    cap_q.delete();
    host_rx_ready = 1'b1;
    repeat (8) tick();
    host_rx_ready = 1'b0;
    check("pace_words", 64'(cap_q.size()), 64'(6));
    if (cap_q.size() == 6) begin
      check("pace_w3", 64'(cap_q[3][31:0]), 64'hB3);
      check("pace_w4", 64'(cap_q[4][31:0]), 64'hB6);
      check("pace_w5", 64'(cap_q[5][31:0]), 64'hB7);
    end

    // 5a. WR FIFO full
    do_reset();
    acc = 0;
    for (int k = 0; k < 100 && acc < DEPTH; k++) begin
      if (!ft601_txe_n) begin
        ft601_wr_n = 1'b0; ft601_be = 4'h3; ft601_data_i = 32'hF000 + 32'(acc);
        acc++;
      end else begin
        ft601_wr_n = 1'b1;
      end
      tick();
    end
    ft601_wr_n = 1'b1;
    check("full_accepted", 64'(acc), 64'(DEPTH));
    check("full_txe_n", 64'(ft601_txe_n), 64'(1));
    ft601_wr_n = 1'b0; ft601_data_i = 32'hBAD;
    tick();
    ft601_wr_n = 1'b1;
    check("full_ovr", 64'(err_ovr_cnt), 64'(1));
    cap_q.delete();
    host_rx_ready = 1'b1;
    repeat (20) tick();
    host_rx_ready = 1'b0;
    check("full_drain", 64'(cap_q.size()), 64'(DEPTH));

    // 5b. RD FIFO full: host push concurrent with FPGA pop is accepted
    do_reset();
    for (int i = 0; i < DEPTH; i++) host_push(32'hC000_0000 + 32'(i));
    check("rdfull_ready", 64'(host_tx_ready), 64'(0));
    ft601_oe_n = 1'b0;
    tick();
    check("rdfull_head", 64'(ft601_data_o), 64'hC000_0000);
    ft601_rd_n = 1'b0; host_tx_valid = 1'b1; host_tx_data = 32'hC000_00FF;
    tick();
    ft601_rd_n = 1'b1; host_tx_valid = 1'b0;
    check("rdfull_still_full", 64'(host_tx_ready), 64'(0));
    rq.delete();
    for (int k = 0; k < 120 && rq.size() < DEPTH; k++) begin
      if (!ft601_rxf_n) begin
        ft601_rd_n = 1'b0;
        rq.push_back(ft601_data_o);
      end else begin
        ft601_rd_n = 1'b1;
      end
      tick();
    end
    ft601_rd_n = 1'b1;
    check("rdfull_drained", 64'(rq.size()), 64'(DEPTH));
    if (rq.size() == DEPTH) begin
      check("rdfull_first", 64'(rq[0]), 64'hC000_0001);
      check("rdfull_last",  64'(rq[DEPTH-1]), 64'hC000_00FF);
    end

    // 6. ft601_rst_n pulse mid-read
    do_reset();
    for (int i = 0; i < 8; i++) host_push(32'hD0 + 32'(i));
    ft601_oe_n = 1'b0;
    tick();
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      if (!ft601_rxf_n) begin ft601_rd_n = 1'b0; n++; end
      else ft601_rd_n = 1'b1;
      tick();
    end
    ft601_rd_n = 1'b1;
    ft601_rst_n = 1'b0;
    tick();
    ft601_rst_n = 1'b1;
    check("crst_rxf_n",    64'(ft601_rxf_n),   64'(1));
    check("crst_data_o",   64'(ft601_data_o),  64'(0));
    check("crst_data_oe",  64'(ft601_data_oe), 64'(0));
    check("crst_tx_ready", 64'(host_tx_ready), 64'(1));
    tick();
    check("crst_rxf_next", 64'(ft601_rxf_n), 64'(1));
    host_push(32'hE0);
    host_push(32'hE1);
    check("crst_new0", 64'(ft601_data_o), 64'hE0);
    ft601_rd_n = 1'b0;
    tick();
    check("crst_new1", 64'(ft601_data_o), 64'hE1);
    tick();
    ft601_rd_n = 1'b1;
    check("crst_empty", 64'(ft601_rxf_n), 64'(1));

    // Randomized traffic against the model
    idle();
    for (int k = 0; k < 3000; k++) begin
      rst           = ($urandom_range(0, 299) == 0);
      ft601_rst_n   = !($urandom_range(0, 249) == 0);
      ft601_oe_n    = ($urandom_range(0, 3) == 0);
      ft601_rd_n    = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : ft601_rxf_n;
      ft601_wr_n    = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : ft601_txe_n;
      ft601_data_i  = $urandom;
      ft601_be      = 4'($urandom_range(0, 15));
      host_tx_valid = 1'($urandom_range(0, 1));
      host_tx_data  = $urandom;
      host_rx_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
